// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: funct3 encodings, FSM states
// and the request decode helpers used by data_mem.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, RESP} state_t;

    // True when the request must be rejected (misaligned or bad encoding).
    function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic misaligned;
        logic illegal;
        misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                     ((funct3 == F3_W) && (addr_lo != 2'b00));
        if (we)
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = funct3 inside {3'b011, 3'b110, 3'b111};
        return misaligned || illegal;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    return 4'b0001 << addr_lo;
            F3_H:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a little-endian word and
// sign- or zero-extends it according to funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign shifted  = word >> {addr_lo, 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = addr_lo[1] ? word[31:16] : word[15:0];

    // NOTE: result gets a default before the case so no latch is inferred.
    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   result = {24'h0, sel_byte};
            F3_H:    result = {{16{sel_half[15]}}, sel_half};
            F3_HU:   result = {16'h0, sel_half};
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised byte-addressable data memory with a two-state
// request/response handshake (one request per two cycles).
module data_mem
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [31:0] mem [WORDS];

    state_t state, state_next;

    logic                  accept;
    logic                  req_err;
    logic [ADDR_WIDTH-3:0] widx;
    logic [3:0]            lanes;
    logic [31:0]           wlanes;

    logic [31:0] word_q;
    logic [1:0]  lo_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        err_q;
    logic [31:0] ext;

    // Address bits above ADDR_WIDTH wrap silently.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH];

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = req_error(we, funct3, addr[1:0]);
    assign widx      = addr[ADDR_WIDTH-1:2];
    assign lanes     = store_lanes(funct3, addr[1:0]);

    always_comb begin
        wlanes = wdata;
        case (funct3)
            F3_B:    wlanes = {4{wdata[7:0]}};
            F3_H:    wlanes = {2{wdata[15:0]}};
            default: wlanes = wdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: the memory array and request capture are deliberately not reset;
    // accept is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= mem[widx];
            lo_q   <= addr[1:0];
            f3_q   <= funct3;
            load_q <= !we;
            err_q  <= req_err;
            if (we && !req_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (lanes[i])
                        mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .word    (word_q),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .result  (ext)
    );

    assign resp_valid = (state == RESP);
    assign err        = resp_valid && err_q;
    assign rdata      = (resp_valid && load_q && !err_q) ? ext : '0;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, giving the byte-address bits used (128 KiB, word-organised, 2^(ADDR_WIDTH-2) words).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 SHALL have port addr  input  32  byte address, driven from the ALU result.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  response present for exactly one cycle.
REQ-011 SHALL have port rdata  output  32  load result, formatted.
REQ-012 SHALL have port err  output  1  request was misaligned or had an illegal funct3.

Function
REQ-013 SHALL implement FSM states IDLE and RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge where req_valid && req_ready; IDLE -> RESP on accept; RESP -> IDLE unconditionally.
REQ-015 SHALL raise resp_valid in the cycle after accept and hold it for one cycle only; no backpressure; peak throughput is one request per 2 cycles.
REQ-016 SHALL sample we/funct3/addr/wdata only at the accept edge; input changes while in RESP SHALL be ignored.
REQ-017 SHALL use address bits [ADDR_WIDTH-1:0] only; higher bits ignored (modulo wrap).
REQ-018 SHALL flag as misaligned: h/hu with addr[0]=1; w with addr[1:0]!=00.
REQ-019 SHALL flag as illegal: loads with funct3 in {011,110,111}; stores with funct3 not in {000,001,010}.
REQ-020 SHALL, on misaligned or illegal requests, perform no write and respond with err=1 and rdata=0.
REQ-021 SHALL, on a legal store, write at the accept edge: sb writes wdata[7:0] to lane addr[1:0]; sh writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; sw writes all 4 lanes (little-endian); other lanes unchanged; response rdata=0, err=0.
REQ-022 SHALL, on a legal load, read the word at the accept edge and present it in RESP: lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged; err=0.
REQ-023 SHALL drive rdata and err to 0 whenever resp_valid=0.

Reset
REQ-024 SHALL, with rst high at a rising edge: set state IDLE, resp_valid=0, rdata=0, err=0; suppress any write at that edge; drop any in-flight response.
REQ-025 SHALL hold req_ready=0 while rst is high.
REQ-026 SHALL leave memory contents unchanged across reset; memory contents SHALL NOT be initialised.

Structure
REQ-027 SHALL take funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum from shared package mem_pkg.
REQ-028 SHALL place lane selection and sign/zero extension in combinational sub-module load_extend (inputs: word, addr[1:0], funct3; output: 32-bit result).

Verification
REQ-029 SHALL check: sw 0xDEADBEEF @0x100, then lw @0x100 -> resp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-030 SHALL check: after REQ-029 data, lb @0x103 -> 0xFFFFFFDE; lbu @0x103 -> 0x000000DE; lh @0x102 -> 0xFFFFDEAD; lhu @0x100 -> 0x0000BEEF.
REQ-031 SHALL check: sb 0x11 @0x101, then lw @0x100 -> 0xDEAD11EF (other lanes preserved).
REQ-032 SHALL check: sw 0x12345678 @0x102 -> err=1, rdata=0; subsequent lw @0x100 returns the unchanged word; load funct3=011 -> err=1.
REQ-033 SHALL check: req_valid held high for 6 cycles -> exactly 3 accepts, req_ready toggling 1/0, resp_valid pulsed once per accept.
REQ-034 SHALL check: rst asserted in RESP -> next cycle resp_valid=0, req_ready=0 while rst high; sw issued at the rst-high edge leaves memory unchanged; address 0x00020100 aliases 0x100 with ADDR_WIDTH=17.
